// File: rtl/conv_d2s_arbiter_pkg.sv
// Shared widths, latency and the extended-single to single conversion rule.
// The global include normally supplies EXTENDED_SINGLE, SINGLE and CONV_D2S_LAT.
`ifndef EXTENDED_SINGLE
`define EXTENDED_SINGLE 43
`endif
`ifndef SINGLE
`define SINGLE 32
`endif
`ifndef CONV_D2S_LAT
`define CONV_D2S_LAT 3
`endif

package conv_d2s_arbiter_pkg;

  localparam int EXT_W        = `EXTENDED_SINGLE;
  localparam int SGL_W        = `SINGLE;
  localparam int CONV_D2S_LAT = `CONV_D2S_LAT;
  localparam int EXT_EXP_W    = 11;
  localparam int EXT_MAN_W    = EXT_W - 1 - EXT_EXP_W;
  localparam int SGL_EXP_W    = 8;
  localparam int SGL_MAN_W    = SGL_W - 1 - SGL_EXP_W;
  localparam int EXP_REBIAS   = 1023 - 127;

  typedef logic [EXT_W-1:0] ext_t;
  typedef logic [SGL_W-1:0] sgl_t;

  // Rebias the exponent, truncate the fraction; denormals flush to zero,
  // out-of-range magnitudes saturate to infinity, NaNs stay quiet NaNs.
  function automatic sgl_t ext_to_single(input ext_t a);
    logic                        s;
    logic [EXT_EXP_W-1:0]        e;
    logic signed [EXT_EXP_W:0]   eb;
    sgl_t                        r;
    s  = a[EXT_W-1];
    e  = a[EXT_W-2 -: EXT_EXP_W];
    eb = $signed({1'b0, e}) - $signed((EXT_EXP_W+1)'(EXP_REBIAS));
    r  = '0;
    if (e == '0)
      r = {s, {(SGL_W-1){1'b0}}};
    else if (&e)
      r = (|a[EXT_MAN_W-1:0]) ? {s, {SGL_EXP_W{1'b1}}, 1'b1, a[EXT_MAN_W-2 -: SGL_MAN_W-1]}
                              : {s, {SGL_EXP_W{1'b1}}, {SGL_MAN_W{1'b0}}};
    else if (eb >= 255)
      r = {s, {SGL_EXP_W{1'b1}}, {SGL_MAN_W{1'b0}}};
    else if (eb <= 0)
      r = {s, {(SGL_W-1){1'b0}}};
    else
      r = {s, eb[SGL_EXP_W-1:0], a[EXT_MAN_W-1 -: SGL_MAN_W]};
    return r;
  endfunction

endpackage

// File: rtl/conv_d2s_arbiter_cvt.sv
// Behavioural stand-in for the pipelined EXTENDED_SINGLE2SINGLE converter IP.
// Same port contract: async clear, clock enable, LAT-cycle result latency.
module conv_d2s_arbiter_cvt
  import conv_d2s_arbiter_pkg::*;
#(
  parameter int LAT = CONV_D2S_LAT
) (
  input  logic             clock,
  input  logic             aclr,
  input  logic             clk_en,
  input  logic [EXT_W-1:0] dataa,
  output logic [SGL_W-1:0] result
);

  sgl_t stage [LAT];

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      for (int i = 0; i < LAT; i++) stage[i] <= '0;
    end else if (clk_en) begin
      stage[0] <= ext_to_single(dataa);
      for (int i = 1; i < LAT; i++) stage[i] <= stage[i-1];
    end
  end

  assign result = stage[LAT-1];

endmodule

// File: rtl/conv_d2s_arbiter_rr_arbiter.sv
// Round-robin request arbiter with registered pointer; one-hot grant.
// Define CONV_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module conv_d2s_arbiter_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDXW = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_vld
);

  logic [IDXW-1:0] ptr;
  logic            found;

  always_comb begin
    // NOTE: every combinational output is defaulted first so no path infers a latch.
    found   = 1'b0;
    gnt_idx = '0;
    grant   = '0;
    // Lowest requester overall covers the wrap-around case; the lowest one at or
    // above the pointer overrides it when present.
    for (int i = NREQ-1; i >= 0; i--) begin
      if (req[i]) begin
        found   = 1'b1;
        gnt_idx = IDXW'(i);
      end
    end
    for (int i = NREQ-1; i >= 0; i--) begin
      if (req[i] && (IDXW'(i) >= ptr)) gnt_idx = IDXW'(i);
    end
    gnt_vld = en && !rst && found;
    if (gnt_vld) grant[gnt_idx] = 1'b1;
  end

`ifdef CONV_ARB_FIXED_PRIO_EN
  // Pointer pinned at zero so the search always starts at requester 0.
  always_ff @(posedge clk) ptr <= '0;
`else
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst)
      ptr <= '0;
    else if (gnt_vld)
      ptr <= (gnt_idx == IDXW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
  end
`endif

endmodule

// File: rtl/conv_d2s_arbiter.sv
// Shares one pipelined extended-single to single converter between NREQ requesters.
// Arbitration mode selected by CONV_ARB_FIXED_PRIO_EN (undefined: round-robin).
module conv_d2s_arbiter
  import conv_d2s_arbiter_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int TAGW     = 2,
  parameter int CONV_LAT = CONV_D2S_LAT
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  input  logic [NREQ-1:0]                 req,
  input  logic [NREQ*`EXTENDED_SINGLE-1:0] x_bus,
  output logic [NREQ-1:0]                 grant,
  output logic [`SINGLE-1:0]              y,
  output logic [NREQ-1:0]                 done,
  output logic                            busy
);

  localparam int IDXW = $clog2(NREQ);

  logic [IDXW-1:0] gnt_idx;
  logic            gnt_vld;
  ext_t            opnd_reg;
  logic            v0;
  logic [TAGW-1:0] t0;
  logic            vld_pipe [CONV_LAT];
  logic [TAGW-1:0] tag_pipe [CONV_LAT];
  sgl_t            cvt_result;
  sgl_t            y_hold;
  logic            out_fire;

  conv_d2s_arbiter_rr_arbiter #(.NREQ(NREQ), .IDXW(IDXW)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .req     (req),
    .grant   (grant),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  // Capture stage: the granted operand is registered into the converter input.
  always_ff @(posedge clk) begin
    if (rst) begin
      opnd_reg <= '0;
      v0       <= 1'b0;
      t0       <= '0;
    end else if (en) begin
      v0 <= gnt_vld;
      if (gnt_vld) begin
        opnd_reg <= x_bus[int'(gnt_idx)*EXT_W +: EXT_W];
        t0       <= TAGW'(gnt_idx);
      end
    end
  end

  conv_d2s_arbiter_cvt #(.LAT(CONV_LAT)) u_cvt (
    .clock  (clk),
    .aclr   (rst),
    .clk_en (en),
    .dataa  (opnd_reg),
    .result (cvt_result)
  );

  // Owner tags travel beside the converter so each result meets its tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: this shift array is a handful of flops, not a RAM, so clearing it on reset is cheap and keeps busy/done clean.
      for (int i = 0; i < CONV_LAT; i++) begin
        vld_pipe[i] <= 1'b0;
        tag_pipe[i] <= '0;
      end
    end else if (en) begin
      vld_pipe[0] <= v0;
      tag_pipe[0] <= t0;
      for (int i = 1; i < CONV_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  assign out_fire = vld_pipe[CONV_LAT-1] && en && !rst;

  always_comb begin
    done = '0;
    for (int i = 0; i < NREQ; i++)
      done[i] = out_fire && (tag_pipe[CONV_LAT-1] == TAGW'(i));
  end

  always_ff @(posedge clk) begin
    if (rst)
      y_hold <= '0;
    else if (out_fire)
      y_hold <= cvt_result;
  end

  assign y = out_fire ? cvt_result : y_hold;

  always_comb begin
    busy = v0;
    for (int i = 0; i < CONV_LAT; i++) busy = busy | vld_pipe[i];
  end

endmodule

// File: doc/conv_d2s_arbiter.md
Name: conv_d2s_arbiter

Overview:
- Shares one pipelined EXTENDED_SINGLE2SINGLE converter between NREQ requesters, e.g. the parallel control-system channels.
- Grants one conversion per enabled cycle and registers the selected operand into the converter.
- Tracks in-flight tags alongside the converter pipeline and returns each result with a one-hot done pulse to its owner.
- Replaces per-channel converter instances in the control-system datapath.

Parameters:
- NREQ, 4: number of requesters, 2..8.
- TAGW, 2: tag width. Must satisfy 2^TAGW >= NREQ.
- CONV_LAT, 3: converter pipeline latency in enabled cycles. Must match the IP configuration.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset. Also drives the converter aclr.
- en  in  1  pipeline advance enable. Drives converter clk_en.
- req  in  NREQ  request per requester. Level-sensitive; operand held while high.
- x_bus  in  NREQ*`EXTENDED_SINGLE  operands, requester i at slice i.
- grant  out  NREQ  one-hot. Pulses in the cycle requester i's operand is captured.
- y  out  `SINGLE  converted result.
- done  out  NREQ  one-hot. Pulses for one cycle when y belongs to requester i.
- busy  out  1  high while any conversion is in flight.

Behaviour:
- Reset (rst=1 at a clk edge):
  - grant, done, y, busy, operand register, tag/valid pipeline all 0.
  - Round-robin pointer = 0.
  - Converter cleared through aclr.
- Reset mid-operation discards all in-flight results; no done is ever emitted for them.
- Arbitration is combinational on req and the pointer, qualified by en and !rst.
  - Round-robin: search from the pointer upward, with wrap-around.
  - grant[i]=1 for the first requester found.
  - On a grant, pointer <= i+1 mod NREQ at the clock edge.
- Capture stage: on a grant edge, opnd_reg <= x_bus slice i, v0 <= 1, t0 <= i. Otherwise v0 <= 0.
- Tag pipeline: CONV_LAT-deep shift of (valid, tag) fed from (v0, t0).
  - Advances only when en=1.
  - Aligned exactly with the converter result.
- Output stage: when the last pipeline valid=1 and en=1:
  - done[tag] pulses for one cycle.
  - y is the converter result and holds until the next done.
  - Otherwise done=0.
- Latency: grant edge to done = 1 + CONV_LAT enabled cycles (4 with defaults).
- Throughput: one conversion per enabled cycle in total. A requester keeping req high is re-granted only after every other pending requester has been served.
- en=0:
  - No grant.
  - Pipeline, pointer and y frozen.
  - done=0.
  - Pending results appear after en returns high; none are lost.
- Requester protocol:
  - Drop req the cycle after grant, or keep it high with a new operand for another conversion.
  - A req with no grant must hold its operand stable.
- No requests: pointer unchanged, no grants.
- busy = OR of v0 and all pipeline valids.
- Ordering: results return in grant order.

Optional Feature:
- Macro CONV_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. Pointer logic removed; pointer reads as constant 0. Starvation of high indices is accepted.
- Undefined: round-robin as described above.

Decomposition:
- Widths `EXTENDED_SINGLE and `SINGLE, plus the converter latency constant CONV_D2S_LAT=3, come from the shared global parameter include. CONV_LAT defaults to that constant.
- Natural sub-module rr_arbiter(NREQ): req, en, pointer update, one-hot grant. It carries the CONV_ARB_FIXED_PRIO_EN switch.
- The converter IP is instantiated directly in the top level.

Test Plan:
- Single request: req=0001, x0=A at cycle 0 -> grant=0001 at cycle 0, done=0001 at cycle 4, y=convert(A); busy high during cycles 1-4.
- All four requesting continuously from cycle 0, pointer at reset -> grants 0001, 0010, 0100, 1000, 0001 in cycles 0-4; dones follow in the same order, 4 cycles later, each y matching its own operand.
- Pointer wrap: req=1001 after a grant to requester 3 -> next grant to requester 0, then 3.
- en low for 2 cycles with 3 conversions in flight -> no done during the stall; results emerge in order once en=1, and each latency is extended by exactly 2.
- rst asserted 2 cycles after a grant -> no done is ever produced for it; all outputs 0 on the next cycle; a request after rst deasserts is granted to requester 0 first.
- CONV_ARB_FIXED_PRIO_EN defined, req=1111 held -> requester 0 is granted every cycle.
